// File: rtl/rvfi_replay_pkg.sv
// Shared types and helpers for the RVFI replay driver: config, record layout, FSM states,
// and the per-cycle lane count function.
package rvfi_replay_pkg;

    typedef struct packed {
        int unsigned NrCommitPorts;
        int unsigned XLEN;
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2, XLEN: 32'd64, VLEN: 32'd64};

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MaxNcp = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef struct packed {
        logic            valid;
        logic            trap;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] mem_paddr;
        logic [7:0]      mem_wmask;
        logic [XLEN-1:0] mem_wdata;
    } rvfi_rec_t;

    // Caller clamps limit to the port count; a trap or invalid record closes its bundle.
    function automatic int unsigned lanes_to_issue(input int unsigned count,
                                                   input int unsigned limit,
                                                   input logic [MaxNcp-1:0] trap_vec,
                                                   input logic [MaxNcp-1:0] valid_vec);
        int unsigned n;
        logic        stop;
        n    = (count < limit) ? count : limit;
        stop = 1'b0;
        for (int unsigned i = 0; i < MaxNcp; i++) begin
            if (!stop && i < n && (trap_vec[i] || !valid_vec[i])) begin
                n    = i + 1;
                stop = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/rvfi_replay_fifo.sv
// Circular record buffer: one push per cycle, pop of 0..NCP heads, combinational view of
// the NCP oldest entries, and a synchronous clear.
module rvfi_replay_fifo
    import rvfi_replay_pkg::*;
#(
    parameter type         rec_t = rvfi_rec_t,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NCP   = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1,
    localparam int unsigned PW   = $clog2(NCP + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear,
    input  logic          push,
    input  rec_t          push_data,
    input  logic [PW-1:0] pop_cnt,
    output logic [CW-1:0] count,
    output rec_t          peek [NCP]
);

    rec_t          mem [DEPTH];
    logic [CW-1:0] wr_ptr_reg;
    logic [CW-1:0] rd_ptr_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + CW'(push);
            rd_ptr_reg <= rd_ptr_reg + CW'(pop_cnt);
        end
    end

    // Storage carries no reset; a write racing a clear lands in a slot that is already dead.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign count = wr_ptr_reg - rd_ptr_reg;

    generate
        for (genvar gi = 0; gi < NCP; gi++) begin : g_peek
            logic [AW-1:0] idx;
            assign idx      = rd_ptr_reg[AW-1:0] + AW'(gi);
            assign peek[gi] = mem[idx];
        end
    endgenerate

endmodule

// File: rtl/rvfi_replay_driver.sv
// Replays buffered retire records as registered RVFI commit bundles and stops on the
// tohost end-of-test store.
module rvfi_replay_driver
    import rvfi_replay_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
    parameter type         rvfi_instr_t = rvfi_rec_t,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned NCP         = CVA6Cfg.NrCommitPorts,
    localparam int unsigned LW          = $clog2(NCP + 1),
    localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rec_valid_i,
    output logic                    rec_ready_o,
    input  rvfi_instr_t             rec_i,
    input  logic [LW-1:0]           max_issue_i,
    input  logic [CVA6Cfg.XLEN-1:0] tohost_addr_i,
    input  logic                    flush_i,
    output rvfi_instr_t             rvfi_o [NCP],
    output logic                    done_o,
    output logic [31:0]             exit_code_o,
    output logic [63:0]             issued_cnt_o
);

    state_e        state_reg, state_next;
    logic          done_reg, done_next;
    logic [31:0]   exit_code_reg, exit_code_next;
    logic [63:0]   issued_cnt_reg, issued_cnt_next;
    rvfi_instr_t   bundle_reg  [NCP];
    rvfi_instr_t   bundle_next [NCP];

    logic          push;
    logic          fifo_clear;
    logic [LW-1:0] pop_cnt;
    logic [CW-1:0] fifo_count;
    rvfi_instr_t   peek [NCP];

    logic [MaxNcp-1:0] trap_vec;
    logic [MaxNcp-1:0] valid_vec;
    int unsigned       limit;
    int unsigned       n_issue;
    logic              hit;

    rvfi_replay_fifo #(
        .rec_t (rvfi_instr_t),
        .DEPTH (DEPTH),
        .NCP   (NCP)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (rec_i),
        .pop_cnt   (pop_cnt),
        .count     (fifo_count),
        .peek      (peek)
    );

    assign rec_ready_o = !rst_i && (state_reg != DONE) && (fifo_count < CW'(DEPTH));
    assign push        = rec_valid_i && rec_ready_o;

    always_comb begin
        state_next      = state_reg;
        done_next       = done_reg;
        exit_code_next  = exit_code_reg;
        issued_cnt_next = issued_cnt_reg;
        fifo_clear      = flush_i;
        pop_cnt         = '0;
        trap_vec        = '0;
        valid_vec       = '0;
        n_issue         = 0;
        hit             = 1'b0;
        for (int unsigned i = 0; i < NCP; i++) begin
            bundle_next[i] = '0;
            trap_vec[i]    = peek[i].trap;
            valid_vec[i]   = peek[i].valid;
        end
        limit = (32'(max_issue_i) > NCP) ? NCP : 32'(max_issue_i);

        if (state_reg != DONE && !flush_i) begin
            n_issue = lanes_to_issue(32'(fifo_count), limit, trap_vec, valid_vec);
        end

        // Lowest tohost hit ends the bundle; everything behind it is dropped.
        for (int unsigned i = 0; i < NCP; i++) begin
            if (!hit && i < n_issue && peek[i].mem_wmask != '0 && tohost_addr_i != '0 &&
                peek[i].mem_paddr == tohost_addr_i && peek[i].mem_wdata[0]) begin
                hit            = 1'b1;
                n_issue        = i + 1;
                exit_code_next = peek[i].mem_wdata[31:0];
            end
        end

        for (int unsigned i = 0; i < NCP; i++) begin
            if (i < n_issue) begin
                bundle_next[i] = peek[i];
                if (peek[i].valid) begin
                    issued_cnt_next = issued_cnt_next + 64'd1;
                end
            end
        end
        pop_cnt = LW'(n_issue);

        if (hit) begin
            fifo_clear = 1'b1;
            pop_cnt    = '0;
            done_next  = 1'b1;
            state_next = DONE;
        end else if (flush_i) begin
            done_next      = 1'b0;
            exit_code_next = '0;
            state_next     = IDLE;
        end else if (state_reg != DONE) begin
            state_next = (fifo_count + CW'(push) != CW'(n_issue)) ? RUN : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            done_reg       <= 1'b0;
            exit_code_reg  <= '0;
            issued_cnt_reg <= '0;
            for (int i = 0; i < NCP; i++) begin
                bundle_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            done_reg       <= done_next;
            exit_code_reg  <= exit_code_next;
            issued_cnt_reg <= issued_cnt_next;
            for (int i = 0; i < NCP; i++) begin
                bundle_reg[i] <= bundle_next[i];
            end
        end
    end

    assign rvfi_o       = bundle_reg;
    assign done_o       = done_reg;
    assign exit_code_o  = exit_code_reg;
    assign issued_cnt_o = issued_cnt_reg;

endmodule

// File: tb/tb_rvfi_replay_driver.sv
// Directed bench for rvfi_replay_driver with two commit ports and an 8-entry buffer.
module tb_rvfi_replay_driver;
    import rvfi_replay_pkg::*;

    localparam int NCP = 2;
    localparam int W   = 512;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rec_valid_i;
    logic        rec_ready_o;
    rvfi_rec_t   rec_i;
    logic [1:0]  max_issue_i;
    logic [63:0] tohost_addr_i;
    logic        flush_i;
    rvfi_rec_t   rvfi_o [NCP];
    logic        done_o;
    logic [31:0] exit_code_o;
    logic [63:0] issued_cnt_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_cnt;
    rvfi_rec_t   zero_rec;
    rvfi_rec_t   st_rec;

    always #5 clk_i = ~clk_i;

    rvfi_replay_driver #(
        .CVA6Cfg (cva6_cfg_empty),
        .DEPTH   (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rec_valid_i   (rec_valid_i),
        .rec_ready_o   (rec_ready_o),
        .rec_i         (rec_i),
        .max_issue_i   (max_issue_i),
        .tohost_addr_i (tohost_addr_i),
        .flush_i       (flush_i),
        .rvfi_o        (rvfi_o),
        .done_o        (done_o),
        .exit_code_o   (exit_code_o),
        .issued_cnt_o  (issued_cnt_o)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic rvfi_rec_t mk(input logic [63:0] pc, input logic v, input logic t,
                                     input logic [63:0] cause, input logic [63:0] paddr,
                                     input logic [7:0] wmask, input logic [63:0] wdata);
        rvfi_rec_t r;
        r           = '0;
        r.valid     = v;
        r.trap      = t;
        r.cause     = cause;
        r.pc        = pc;
        r.insn      = (wmask != 8'h0) ? 32'h00a5_2023 : 32'h0010_0093;
        r.rd_addr   = (wmask != 8'h0) ? 5'd0 : 5'd1;
        r.rd_wdata  = pc ^ 64'h55;
        r.mem_paddr = paddr;
        r.mem_wmask = wmask;
        r.mem_wdata = wdata;
        return r;
    endfunction

    function automatic rvfi_rec_t alu(input logic [63:0] pc);
        return mk(pc, 1'b1, 1'b0, 64'h0, 64'h0, 8'h0, 64'h0);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_rec(input rvfi_rec_t r);
        rec_valid_i = 1'b1;
        rec_i       = r;
        step();
        rec_valid_i = 1'b0;
    endtask

    task automatic check_bundle(input string tag, input rvfi_rec_t e0, input rvfi_rec_t e1);
        $display("bundle %s: lane0 v=%0b pc=%0h lane1 v=%0b pc=%0h", tag,
                 rvfi_o[0].valid, rvfi_o[0].pc, rvfi_o[1].valid, rvfi_o[1].pc);
        check({tag, "_l0"}, W'(rvfi_o[0]), W'(e0));
        check({tag, "_l1"}, W'(rvfi_o[1]), W'(e1));
    endtask

    initial begin
        zero_rec      = '0;
        rst_i         = 1'b1;
        rec_valid_i   = 1'b0;
        rec_i         = '0;
        max_issue_i   = 2'd0;
        tohost_addr_i = 64'h0;
        flush_i       = 1'b0;
        exp_cnt       = 64'd0;

        // Reset state
        step();
        check_bundle("rst", zero_rec, zero_rec);
        check("rst_done", W'(done_o), W'(1'b0));
        check("rst_exit", W'(exit_code_o), W'(32'h0));
        check("rst_cnt", W'(issued_cnt_o), W'(64'h0));
        check("rst_ready", W'(rec_ready_o), W'(1'b0));
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", W'(rec_ready_o), W'(1'b1));

        // 1) four ALU records, issued two per cycle once released
        for (int i = 0; i < 4; i++) push_rec(alu(64'h100 + 64'(4 * i)));
        check_bundle("t1_stall", zero_rec, zero_rec);
        max_issue_i = 2'd2;
        step();
        check_bundle("t1_b0", alu(64'h100), alu(64'h104));
        step();
        check_bundle("t1_b1", alu(64'h108), alu(64'h10c));
        step();
        check_bundle("t1_idle", zero_rec, zero_rec);
        exp_cnt = 64'd4;
        check("t1_cnt", W'(issued_cnt_o), W'(exp_cnt));

        // 2) invalid trap record closes its bundle and is not counted
        max_issue_i = 2'd0;
        push_rec(alu(64'h200));
        push_rec(mk(64'h204, 1'b0, 1'b1, 64'd2, 64'h0, 8'h0, 64'h0));
        push_rec(alu(64'h208));
        max_issue_i = 2'd2;
        step();
        check_bundle("t2_b0", alu(64'h200), mk(64'h204, 1'b0, 1'b1, 64'd2, 64'h0, 8'h0, 64'h0));
        step();
        check_bundle("t2_b1", alu(64'h208), zero_rec);
        exp_cnt = 64'd6;
        check("t2_cnt", W'(issued_cnt_o), W'(exp_cnt));

        // 2b) valid trap on lane 0 is issued alone and counted
        max_issue_i = 2'd0;
        push_rec(mk(64'h20c, 1'b1, 1'b1, 64'd5, 64'h0, 8'h0, 64'h0));
        push_rec(alu(64'h210));
        max_issue_i = 2'd2;
        step();
        check_bundle("t2b_b0", mk(64'h20c, 1'b1, 1'b1, 64'd5, 64'h0, 8'h0, 64'h0), zero_rec);
        step();
        check_bundle("t2b_b1", alu(64'h210), zero_rec);
        exp_cnt = 64'd8;
        check("t2b_cnt", W'(issued_cnt_o), W'(exp_cnt));

        // 3) tohost store ends the test; queued record is dropped
        tohost_addr_i = 64'h8000_1000;
        max_issue_i   = 2'd0;
        st_rec        = mk(64'h300, 1'b1, 1'b0, 64'h0, 64'h8000_1000, 8'h0f, 64'h1);
        push_rec(st_rec);
        push_rec(alu(64'h304));
        max_issue_i = 2'd2;
        step();
        check_bundle("t3_hit", st_rec, zero_rec);
        check("t3_done", W'(done_o), W'(1'b1));
        check("t3_exit", W'(exit_code_o), W'(32'h1));
        check("t3_ready", W'(rec_ready_o), W'(1'b0));
        exp_cnt = 64'd9;
        check("t3_cnt", W'(issued_cnt_o), W'(exp_cnt));
        step();
        check_bundle("t3_after", zero_rec, zero_rec);
        check("t3_done_sticky", W'(done_o), W'(1'b1));
        check("t3_cnt_hold", W'(issued_cnt_o), W'(exp_cnt));

        // Flush from DONE re-opens the input, keeps the counter
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("fl_done", W'(done_o), W'(1'b0));
        check("fl_exit", W'(exit_code_o), W'(32'h0));
        check("fl_ready", W'(rec_ready_o), W'(1'b1));
        check("fl_cnt", W'(issued_cnt_o), W'(exp_cnt));
        push_rec(alu(64'h500));
        step();
        check_bundle("fl_b0", alu(64'h500), zero_rec);
        exp_cnt = 64'd10;
        check("fl_cnt2", W'(issued_cnt_o), W'(exp_cnt));

        // 4) fill past capacity while stalled, then drain in order
        tohost_addr_i = 64'h0;
        max_issue_i   = 2'd0;
        step();
        for (int i = 0; i < 10; i++) begin
            rec_valid_i = 1'b1;
            rec_i       = alu(64'h400 + 64'(4 * i));
            #1;
            check($sformatf("t4_ready%0d", i), W'(rec_ready_o), W'(i < 8));
            step();
        end
        rec_valid_i = 1'b0;
        max_issue_i = 2'd2;
        for (int j = 0; j < 4; j++) begin
            step();
            check_bundle($sformatf("t4_b%0d", j), alu(64'h400 + 64'(8 * j)), alu(64'h404 + 64'(8 * j)));
        end
        step();
        check_bundle("t4_empty", zero_rec, zero_rec);
        exp_cnt = 64'd18;
        check("t4_cnt", W'(issued_cnt_o), W'(exp_cnt));

        // 6a) tohost store with wdata bit0 clear does not end the test
        tohost_addr_i = 64'h8000_1000;
        max_issue_i   = 2'd0;
        st_rec        = mk(64'h600, 1'b1, 1'b0, 64'h0, 64'h8000_1000, 8'hff, 64'h0);
        push_rec(st_rec);
        push_rec(alu(64'h604));
        max_issue_i = 2'd2;
        step();
        check_bundle("t6a_b0", st_rec, alu(64'h604));
        check("t6a_done", W'(done_o), W'(1'b0));

        // 6b) detection disabled with tohost address zero
        tohost_addr_i = 64'h0;
        max_issue_i   = 2'd0;
        st_rec        = mk(64'h700, 1'b1, 1'b0, 64'h0, 64'h8000_1000, 8'hff, 64'h1);
        push_rec(st_rec);
        push_rec(alu(64'h704));
        max_issue_i = 2'd2;
        step();
        check_bundle("t6b_b0", st_rec, alu(64'h704));
        check("t6b_done", W'(done_o), W'(1'b0));
        check("t6b_ready", W'(rec_ready_o), W'(1'b1));
        exp_cnt = 64'd22;
        check("t6_cnt", W'(issued_cnt_o), W'(exp_cnt));

        // 5) reset with five buffered records and an issue pending
        max_issue_i = 2'd0;
        step();
        for (int i = 0; i < 5; i++) push_rec(alu(64'h800 + 64'(4 * i)));
        max_issue_i = 2'd2;
        rst_i       = 1'b1;
        step();
        check_bundle("t5_rst", zero_rec, zero_rec);
        check("t5_cnt", W'(issued_cnt_o), W'(64'h0));
        check("t5_done", W'(done_o), W'(1'b0));
        check("t5_ready_in_rst", W'(rec_ready_o), W'(1'b0));
        rst_i = 1'b0;
        #1;
        check("t5_ready", W'(rec_ready_o), W'(1'b1));
        step();
        check_bundle("t5_empty", zero_rec, zero_rec);
        check("t5_cnt2", W'(issued_cnt_o), W'(64'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
